// File: rtl/ping_pong_monitor_pkg.sv
// ---------------------------------------------------------------------------
// ping_pong_monitor_pkg : shared FSM encoding, direction codes, MAX helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ping_pong_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  function automatic logic [31:0] max_of(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ping_pong_monitor_step.sv
// ---------------------------------------------------------------------------
// ping_pong_step : combinational next-sample predictor for a ping-pong counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ping_pong_step
  import ping_pong_monitor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] v_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] v_o,
  output logic             d_o
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));

  always_comb begin
    v_o = v_i;
    d_o = d_i;
    if (d_i == UP && v_i == MAX) begin
      v_o = MAX - 1'b1;
      d_o = DOWN;
    end else if (d_i == DOWN && v_i == '0) begin
      v_o = {{(WIDTH-1){1'b0}}, 1'b1};
      d_o = UP;
    end else if (d_i == UP) begin
      v_o = v_i + 1'b1;
    end else begin
      v_o = v_i - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ping_pong_monitor.sv
// ---------------------------------------------------------------------------
// ping_pong_monitor : lock / mismatch / turnaround checker for a ping-pong stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ping_pong_monitor
  import ping_pong_monitor_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 2,
  parameter int BNC_W    = 8,
  parameter int ERR_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_dir,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic             top,
  output logic             bottom,
  output logic [BNC_W-1:0] bounce_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);

  state_e             state_q;
  logic [WIDTH-1:0]   ref_v_q;
  logic               ref_d_q;
  logic [3:0]         match_cnt_q;
  logic               locked_q, err_q, top_q, bottom_q;
  logic [BNC_W-1:0]   bnc_q;
  logic [ERR_W-1:0]   errc_q;

  logic [WIDTH-1:0]   pred_v_d;
  logic               pred_d_d;
  logic               match_d;

  ping_pong_step #(.WIDTH(WIDTH)) u_step (
    .v_i (ref_v_q),
    .d_i (ref_d_q),
    .v_o (pred_v_d),
    .d_o (pred_d_d)
  );

  assign match_d = (pred_v_d == in_value) && (pred_d_d == in_dir);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ref_v_q     <= '0;
      ref_d_q     <= 1'b0;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      top_q       <= 1'b0;
      bottom_q    <= 1'b0;
      bnc_q       <= '0;
      errc_q      <= '0;
    end else begin
      err_q    <= 1'b0;
      top_q    <= 1'b0;
      bottom_q <= 1'b0;
      if (in_valid) begin
        // Every accepted sample becomes the reference, match or not.
        ref_v_q <= in_value;
        ref_d_q <= in_dir;
        case (state_q)
          IDLE: begin
            match_cnt_q <= '0;
            state_q     <= TRACK;
          end
          TRACK: begin
            if (!match_d) begin
              match_cnt_q <= '0;
            end else if (match_cnt_q + 4'd1 == LOCK_N) begin
              match_cnt_q <= '0;
              state_q     <= LOCKED;
              locked_q    <= 1'b1;
            end else begin
              match_cnt_q <= match_cnt_q + 4'd1;
            end
          end
          LOCKED: begin
            if (match_d) begin
              if (in_dir != ref_d_q) begin
                top_q    <= (in_dir == DOWN);
                bottom_q <= (in_dir == UP);
                bnc_q    <= bnc_q + 1'b1;
              end
            end else begin
              err_q       <= 1'b1;
              if (errc_q != '1) errc_q <= errc_q + 1'b1;
              match_cnt_q <= '0;
              state_q     <= TRACK;
              locked_q    <= 1'b0;
            end
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
      // Later assignment overrides any increment made above this edge.
      if (clr) begin
        bnc_q  <= '0;
        errc_q <= '0;
      end
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign top        = top_q;
  assign bottom     = bottom_q;
  assign bounce_cnt = bnc_q;
  assign err_cnt    = errc_q;

endmodule

`default_nettype wire

// File: tb/tb_ping_pong_monitor.sv
// ---------------------------------------------------------------------------
// tb_ping_pong_monitor : directed + randomized bench with a reflection-based model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ping_pong_monitor;

  localparam int WIDTH    = 4;
  localparam int LOCK_LEN = 2;
  localparam int BNC_W    = 8;
  localparam int ERR_W    = 2;
  localparam int MAXV     = (1 << WIDTH) - 1;
  localparam int ERR_SAT  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_value = '0;
  logic             in_dir = 1'b0;
  logic             clr = 1'b0;
  logic             locked, err, top, bottom;
  logic [BNC_W-1:0] bounce_cnt;
  logic [ERR_W-1:0] err_cnt;

  ping_pong_monitor #(
    .WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .BNC_W(BNC_W), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
    .in_dir(in_dir), .clr(clr), .locked(locked), .err(err), .top(top),
    .bottom(bottom), .bounce_cnt(bounce_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a trusted reference sample plus a streak of correct steps.
  bit m_have;
  int m_v;
  bit m_d;
  int m_streak;
  int m_bnc;
  int m_errc;
  bit e_err, e_top, e_bot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next sample by moving one step and reflecting off the walls 0 and MAX.
  task automatic predict(input int v, input bit d, output int nv, output bit nd);
    int n;
    n = d ? v + 1 : v - 1;
    nd = d;
    if (n > MAXV) begin
      n  = 2 * MAXV - n;
      nd = 1'b0;
    end else if (n < 0) begin
      n  = -n;
      nd = 1'b1;
    end
    nv = n;
  endtask

  function automatic bit m_locked();
    return m_have && (m_streak >= LOCK_LEN);
  endfunction

  task automatic model_reset();
    m_have = 0; m_v = 0; m_d = 0; m_streak = 0;
    m_bnc = 0; m_errc = 0; e_err = 0; e_top = 0; e_bot = 0;
  endtask

  task automatic model_step(input bit vld, input int val, input bit dir, input bit c);
    int pv;
    bit pd, ok, was_locked;
    e_err = 0; e_top = 0; e_bot = 0;
    if (vld) begin
      if (!m_have) begin
        m_have = 1;
        m_streak = 0;
      end else begin
        predict(m_v, m_d, pv, pd);
        ok = (pv == val) && (pd == dir);
        was_locked = m_locked();
        if (ok) begin
          m_streak++;
          if (was_locked && dir != m_d) begin
            if (dir) e_bot = 1; else e_top = 1;
            m_bnc = (m_bnc + 1) % (1 << BNC_W);
          end
        end else begin
          m_streak = 0;
          if (was_locked) begin
            e_err = 1;
            if (m_errc < ERR_SAT) m_errc++;
          end
        end
      end
      m_v = val;
      m_d = dir;
    end
    if (c) begin
      m_bnc = 0;
      m_errc = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked"}, 32'(locked), 32'(m_locked()));
    check({tag, ".err"}, 32'(err), 32'(e_err));
    check({tag, ".top"}, 32'(top), 32'(e_top));
    check({tag, ".bottom"}, 32'(bottom), 32'(e_bot));
    check({tag, ".bounce_cnt"}, 32'(bounce_cnt), 32'(m_bnc));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_errc));
  endtask

  task automatic step(input string tag, input bit vld, input int val, input bit dir, input bit c);
    in_valid = vld;
    in_value = WIDTH'(val);
    in_dir   = dir;
    clr      = c;
    @(posedge clk);
    model_step(vld, val, dir, c);
    #1;
    check_all(tag);
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic good_step(input string tag);
    int pv;
    bit pd;
    predict(m_v, m_d, pv, pd);
    step(tag, 1'b1, pv, pd, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    clr   = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check_all(tag);
    check({tag, ".state"}, 32'(dut.state_q), 32'd0);
    rst_n = 1'b1;
    clr   = 1'b0;
  endtask

  initial begin
    int pv;
    bit pd;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset");

    step("lock0", 1, 0, 1, 0);
    step("lock1", 1, 1, 1, 0);
    step("lock2", 1, 2, 1, 0);
    check("lock_done", 32'(locked), 32'd1);

    for (int v = 3; v <= MAXV; v++) step("sweep_up", 1, v, 1, 0);
    for (int v = MAXV - 1; v >= 0; v--) step("sweep_dn", 1, v, 0, 0);
    step("sweep_bot", 1, 1, 1, 0);
    check("sweep_bnc", 32'(bounce_cnt), 32'd2);

    for (int v = 2; v <= 5; v++) step("pre_mis", 1, v, 1, 0);
    step("mismatch", 1, 7, 1, 0);
    check("mis_err", 32'(err), 32'd1);
    check("mis_errcnt", 32'(err_cnt), 32'd1);
    step("relock8", 1, 8, 1, 0);
    step("relock9", 1, 9, 1, 0);
    check("relocked", 32'(locked), 32'd1);

    for (int i = 0; i < 40 && !(m_v == 4 && m_d == 0); i++) good_step("to_gap");
    check("gap_ref", 32'(m_v), 32'd4);
    for (int i = 0; i < 10; i++) step("gap_idle", 0, $urandom_range(0, MAXV), $urandom_range(0, 1), 0);
    step("gap_resume", 1, 3, 0, 0);
    check("gap_locked", 32'(locked), 32'd1);

    for (int k = 1; k <= 6; k++) begin
      predict(m_v, m_d, pv, pd);
      step("sat_mis", 1, pv, !pd, k == 6);
      check("sat_pulse", 32'(err), 32'd1);
      good_step("sat_relock");
      good_step("sat_relock");
    end
    check("sat_clr", 32'(err_cnt), 32'd0);

    for (int i = 0; i < 300 && m_bnc != 7; i++) good_step("to_bnc7");
    check("bnc7", 32'(bounce_cnt), 32'd7);
    do_reset("mid_reset");
    step("post_reset", 1, 9, 0, 0);
    check("post_reset_err", 32'(err), 32'd0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_reset");
      end else if (m_have && $urandom_range(0, 7) != 0) begin
        predict(m_v, m_d, pv, pd);
        step("rnd", $urandom_range(0, 3) != 0, pv, pd, $urandom_range(0, 19) == 0);
      end else begin
        step("rnd_x", $urandom_range(0, 3) != 0, $urandom_range(0, MAXV),
             $urandom_range(0, 1), $urandom_range(0, 19) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
